// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg: shared constants and types for the ID/EX stage and its neighbours.
//   XLEN / RA_W        : datapath and register-address widths
//   ALU_*              : 4-bit ALU opcodes carried in alu_control
//   ctrl_t             : decoded control bundle registered by the stage
//   CTRL_RESET         : all-zero control bundle used on reset
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    alu_src:     1'b0,
    alu_control: 4'b0000
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if: ID/EX -> EX handshake and operand bus.
//   master (ID/EX stage): drives ex_valid, operands, opcode, store data,
//                         destination and control bits; samples ex_ready
//   slave  (EX stage)   : samples everything above; drives ex_ready
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_in1;
  logic [XLEN-1:0] ex_in2;
  logic [3:0]      ex_alu_control;
  logic [XLEN-1:0] ex_store_data;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;

  modport master (
    output ex_valid, ex_in1, ex_in2, ex_alu_control, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_in1, ex_in2, ex_alu_control, ex_store_data,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
    output ex_ready
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux: operand forwarding selector for one source register.
//   addr / raw          : source register index and its register-file value
//   exmem_* / memwb_*   : destination, write enable and result of the two
//                         younger in-flight instructions
//   data                : EX/MEM result, else MEM/WB result, else raw.
//                         x0 is never forwarded.
// Shared with the EX/MEM stage.
// ---------------------------------------------------------------------------
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] raw,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] data
);

  logic addr_nz_s;
  logic hit_exmem_s;
  logic hit_memwb_s;

  // Match detection against each producer.
  always_comb begin
    addr_nz_s   = (addr != {RA_W{1'b0}});
    hit_exmem_s = exmem_reg_write && (exmem_rd_addr == addr) && addr_nz_s;
    hit_memwb_s = memwb_reg_write && (memwb_rd_addr == addr) && addr_nz_s;
  end

  // Priority select: the younger producer (EX/MEM) wins.
  always_comb begin
    data = raw;
    if (hit_exmem_s) begin
      data = exmem_result;
    end else if (hit_memwb_s) begin
      data = memwb_result;
    end else begin
      data = raw;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage: ID/EX pipeline register in front of the ALU.
// Registers decoded operands/control, forwards from EX/MEM and MEM/WB,
// and bubbles on load-use hazards.
//   clk, rst             : clock, synchronous active-high reset
//   id_*                 : decode slot (valid/ready, operands, control)
//   exmem_*, memwb_*     : forwarding sources
//   flush                : kill held and incoming entry
//   ex (master modport)  : handshake + ALU operands to EX
//   load_use_stall       : load-use hazard indicator
// Optional build macro IDEX_PERF_EN adds perf_stall_cnt / perf_bubble_cnt.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_control,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            flush,
  id_ex_stage_if.master   ex,
  output logic            load_use_stall
`ifdef IDEX_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  import riscv_pkg::*;

  logic            valid_r;
  logic [RA_W-1:0] rs1_r;
  logic [RA_W-1:0] rs2_r;
  logic [XLEN-1:0] rs1_data_r;
  logic [XLEN-1:0] rs2_data_r;
  logic [XLEN-1:0] imm_r;
  logic [RA_W-1:0] rd_r;
  ctrl_t           ctrl_r;

  ctrl_t           id_ctrl_s;
  logic [XLEN-1:0] fwd_rs1_s;
  logic [XLEN-1:0] fwd_rs2_s;
  logic            accept_s;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr            (rs1_r),
    .raw             (rs1_data_r),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .data            (fwd_rs1_s)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr            (rs2_r),
    .raw             (rs2_data_r),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .data            (fwd_rs2_s)
  );

  // Pack incoming decode control into the stored bundle.
  always_comb begin
    id_ctrl_s             = CTRL_RESET;
    id_ctrl_s.reg_write   = id_reg_write;
    id_ctrl_s.mem_read    = id_mem_read;
    id_ctrl_s.mem_write   = id_mem_write;
    id_ctrl_s.alu_src     = id_alu_src;
    id_ctrl_s.alu_control = id_alu_control;
  end

  // Load-use detection and upstream ready. An rs2 match stalls even for
  // immediate-form instructions: stores still consume rs2.
  always_comb begin
    load_use_stall = valid_r && ctrl_r.mem_read && (rd_r != {RA_W{1'b0}}) &&
                     id_valid && ((rd_r == id_rs1_addr) || (rd_r == id_rs2_addr));
    id_ready       = (!valid_r || ex.ex_ready) && !load_use_stall && !flush;
    accept_s       = id_valid && id_ready;
  end

  // Drive the EX bus; control bits are squashed while no entry is held.
  always_comb begin
    ex.ex_valid       = valid_r;
    ex.ex_in1         = fwd_rs1_s;
    ex.ex_in2         = ctrl_r.alu_src ? imm_r : fwd_rs2_s;
    ex.ex_store_data  = fwd_rs2_s;
    ex.ex_alu_control = ctrl_r.alu_control;
    ex.ex_rd_addr     = rd_r;
    ex.ex_reg_write   = valid_r && ctrl_r.reg_write;
    ex.ex_mem_read    = valid_r && ctrl_r.mem_read;
    ex.ex_mem_write   = valid_r && ctrl_r.mem_write;
  end

  // Stage register: reset > flush > accept > consume > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      rs1_r      <= {RA_W{1'b0}};
      rs2_r      <= {RA_W{1'b0}};
      rs1_data_r <= {XLEN{1'b0}};
      rs2_data_r <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      rd_r       <= {RA_W{1'b0}};
      ctrl_r     <= CTRL_RESET;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r    <= 1'b1;
      rs1_r      <= id_rs1_addr;
      rs2_r      <= id_rs2_addr;
      rs1_data_r <= id_rs1_data;
      rs2_data_r <= id_rs2_data;
      imm_r      <= id_imm;
      rd_r       <= id_rd_addr;
      ctrl_r     <= id_ctrl_s;
    end else if (valid_r && ex.ex_ready) begin
      valid_r <= 1'b0;
    end else if (valid_r) begin
      // Stalled: latch forwarded values so they survive producer retirement.
      rs1_data_r <= fwd_rs1_s;
      rs2_data_r <= fwd_rs2_s;
    end
  end

`ifdef IDEX_PERF_EN
  // Stall and bubble counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      perf_stall_cnt  <= load_use_stall ? perf_stall_cnt + 32'd1 : perf_stall_cnt;
      perf_bubble_cnt <= !valid_r ? perf_bubble_cnt + 32'd1 : perf_bubble_cnt;
    end
  end
`endif

endmodule
